// File: rtl/bram_arb_pkg.sv
// ---------------------------------------------------------------------------
// bram_arb_pkg
// Shared types and helpers for bram_port_arbiter.
//   arb_state_t : arbiter FSM states (IDLE -> BUSY -> RESP -> IDLE)
//   OWN_I/OWN_D : encodings of the owner register (instruction / data side)
//   cnt_width   : bits needed for a counter that must hold 0..max_val
// ---------------------------------------------------------------------------
package bram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
// Registered two-requester arbiter in front of the single cache-line BRAM
// port. The data path wins ties; the instruction path is guaranteed a grant
// after STARVE_LIMIT consecutive data grants taken while it was waiting.
// A transaction that sees no mem_valid within TIMEOUT cycles is aborted and
// reported to its owner with an err pulse instead of a valid pulse.
//
// Ports
//   sys_clock, reset              clock, synchronous active-high reset
//   i_req/i_write/i_addr/i_wdata  instruction request (level, held to done)
//   i_rdata/i_valid/i_err         instruction response
//   d_req/d_write/d_addr/d_wdata  data request (level, held to done)
//   d_wenc                        encrypted tag for data-path writes
//   d_rdata/d_renc/d_valid/d_err  data response
//   mem_req/mem_write/mem_addr/
//   mem_wdata/mem_wenc            BRAM command (registered, stable in BUSY)
//   mem_rdata/mem_renc/mem_valid  BRAM response
// ---------------------------------------------------------------------------
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_BITS    = 15,
    parameter int DATA_W       = 128,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                 sys_clock,
    input  logic                 reset,

    input  logic                 i_req,
    input  logic                 i_write,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [DATA_W-1:0]    i_wdata,
    output logic [DATA_W-1:0]    i_rdata,
    output logic                 i_valid,
    output logic                 i_err,

    input  logic                 d_req,
    input  logic                 d_write,
    input  logic [ADDR_BITS-1:0] d_addr,
    input  logic [DATA_W-1:0]    d_wdata,
    input  logic                 d_wenc,
    output logic [DATA_W-1:0]    d_rdata,
    output logic                 d_renc,
    output logic                 d_valid,
    output logic                 d_err,

    output logic                 mem_req,
    output logic                 mem_write,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    output logic                 mem_wenc,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 mem_renc,
    input  logic                 mem_valid
);

    localparam int STARVE_W = cnt_width(STARVE_LIMIT);
    localparam int TMO_W    = cnt_width(TIMEOUT);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    // Abort fires on the edge that closes the TIMEOUT-th BUSY cycle.
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);

    arb_state_t            r_state;
    logic                  r_owner;
    logic [STARVE_W-1:0]   r_starve;
    logic [TMO_W-1:0]      r_tmo;

    logic                  r_mem_req;
    logic                  r_mem_write;
    logic [ADDR_BITS-1:0]  r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic                  r_mem_wenc;

    logic [DATA_W-1:0]     r_rdata;
    logic                  r_renc;
    logic                  r_i_valid;
    logic                  r_i_err;
    logic                  r_d_valid;
    logic                  r_d_err;

    logic                  w_starved;
    logic                  w_pick_i;
    logic                  w_any_req;
    logic [STARVE_W-1:0]   w_starve_inc;

    // Instruction side wins only when alone or when it has waited long enough.
    assign w_starved    = (r_starve == STARVE_MAX);
    assign w_pick_i     = i_req & (~d_req | w_starved);
    assign w_any_req    = i_req | d_req;
    assign w_starve_inc = w_starved ? r_starve : (r_starve + 1'b1);

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_owner     <= OWN_D;
            r_starve    <= '0;
            r_tmo       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wenc  <= 1'b0;
            r_rdata     <= '0;
            r_renc      <= 1'b0;
            r_i_valid   <= 1'b0;
            r_i_err     <= 1'b0;
            r_d_valid   <= 1'b0;
            r_d_err     <= 1'b0;
        end else begin
            // Completion/abort flags are single-cycle pulses.
            r_i_valid <= 1'b0;
            r_i_err   <= 1'b0;
            r_d_valid <= 1'b0;
            r_d_err   <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_tmo <= '0;
                    if (w_any_req) begin
                        r_mem_req <= 1'b1;
                        r_state   <= BUSY;
                        if (w_pick_i) begin
                            r_owner     <= OWN_I;
                            r_mem_write <= i_write;
                            r_mem_addr  <= i_addr;
                            r_mem_wdata <= i_wdata;
                            r_mem_wenc  <= 1'b0;   // fetch path is never encrypted
                            r_starve    <= '0;
                        end else begin
                            r_owner     <= OWN_D;
                            r_mem_write <= d_write;
                            r_mem_addr  <= d_addr;
                            r_mem_wdata <= d_wdata;
                            r_mem_wenc  <= d_wenc;
                            // Only grants that bypass a waiting fetch count toward starvation.
                            r_starve    <= i_req ? w_starve_inc : '0;
                        end
                    end
                end

                BUSY: begin
                    // Requester inputs are not looked at here; the latched command holds.
                    if (mem_valid) begin
                        r_mem_req <= 1'b0;
                        r_rdata   <= mem_rdata;
                        r_renc    <= mem_renc;
                        r_state   <= RESP;
                        if (r_owner == OWN_I) begin
                            r_i_valid <= 1'b1;
                        end else begin
                            r_d_valid <= 1'b1;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        r_mem_req <= 1'b0;
                        r_state   <= RESP;
                        if (r_owner == OWN_I) begin
                            r_i_err <= 1'b1;
                        end else begin
                            r_d_err <= 1'b1;
                        end
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end

                RESP: begin
                    // Requester drops req during this cycle; sampling resumes in IDLE.
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wenc  = r_mem_wenc;

    // One registered read copy feeds both sides; it holds until the next completion.
    assign i_rdata = r_rdata;
    assign d_rdata = r_rdata;
    assign d_renc  = r_renc;
    assign i_valid = r_i_valid;
    assign i_err   = r_i_err;
    assign d_valid = r_d_valid;
    assign d_err   = r_d_err;

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;

    localparam int AW           = 15;
    localparam int DW           = 128;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 255;

    logic          sys_clock;
    logic          reset;
    logic          i_req, i_write;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_wdata, i_rdata;
    logic          i_valid, i_err;
    logic          d_req, d_write, d_wenc;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          d_renc, d_valid, d_err;
    logic          mem_req, mem_write, mem_wenc;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_renc, mem_valid;

    int checks   = 0;
    int failures = 0;

    bram_port_arbiter #(
        .ADDR_BITS(AW), .DATA_W(DW), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .sys_clock(sys_clock), .reset(reset),
        .i_req(i_req), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_valid(i_valid), .i_err(i_err),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wenc(d_wenc), .d_rdata(d_rdata), .d_renc(d_renc), .d_valid(d_valid), .d_err(d_err),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wenc(mem_wenc), .mem_rdata(mem_rdata), .mem_renc(mem_renc), .mem_valid(mem_valid)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    function automatic logic [DW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; i_write = 0; i_addr = '0; i_wdata = '0;
        d_req = 0; d_write = 0; d_addr = '0; d_wdata = '0; d_wenc = 0;
        mem_rdata = '0; mem_renc = 0; mem_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_inputs();
        step();
        reset = 0;
        step();
    endtask

    task automatic test_reset();
        reset = 1;
        i_req = 1; d_req = 1; d_write = 1; d_wenc = 1;
        d_addr = 15'h1234; d_wdata = rand_line();
        mem_valid = 1; mem_rdata = rand_line(); mem_renc = 1;
        step(); step();
        checks++;
        if ({mem_req, mem_write, mem_addr, mem_wdata, mem_wenc} !== '0) begin
            failures++;
            $display("FAIL reset_mem_side: got req=%b wr=%b addr=%h enc=%b expected all 0",
                     mem_req, mem_write, mem_addr, mem_wenc);
        end
        checks++;
        if ({i_valid, i_err, d_valid, d_err, d_renc, i_rdata, d_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_resp_side: got iv=%b ie=%b dv=%b de=%b renc=%b expected all 0",
                     i_valid, i_err, d_valid, d_err, d_renc);
        end
        reset = 0;
        idle_inputs();
        step(); step();
        checks++;
        if ({mem_req, i_valid, d_valid, i_err, d_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_idle_quiet: got req=%b iv=%b dv=%b ie=%b de=%b expected 0",
                     mem_req, i_valid, d_valid, i_err, d_err);
        end
        $display("txn reset: done");
    endtask

    task automatic test_read_latency();
        logic [DW-1:0] pat;
        pat = {16{8'hA5}};
        do_reset();
        d_req = 1; d_write = 0; d_addr = 15'h0010;          // cycle 0
        step();                                             // cycle 1
        checks++;
        if ({mem_req, mem_write, mem_addr} !== {1'b1, 1'b0, 15'h0010}) begin
            failures++;
            $display("FAIL lat_cmd: got req=%b wr=%b addr=%h expected 1 0 0010", mem_req, mem_write, mem_addr);
        end
        step(); step();                                     // cycle 3
        checks++;
        if (mem_req !== 1'b1 || d_valid !== 1'b0) begin
            failures++;
            $display("FAIL lat_hold: got req=%b dv=%b expected 1 0", mem_req, d_valid);
        end
        step();                                             // cycle 4
        mem_valid = 1; mem_rdata = pat; mem_renc = 1;
        step();                                             // cycle 5
        mem_valid = 0; mem_rdata = '0; mem_renc = 0;
        checks++;
        if ({d_valid, i_valid, d_err, mem_req} !== 4'b1000 || d_rdata !== pat || d_renc !== 1'b1) begin
            failures++;
            $display("FAIL lat_resp: got dv=%b iv=%b de=%b req=%b renc=%b rdata=%h expected 1 0 0 0 1 %h",
                     d_valid, i_valid, d_err, mem_req, d_renc, d_rdata, pat);
        end
        d_req = 0;
        step();                                             // cycle 6
        checks++;
        if (d_valid !== 1'b0 || d_rdata !== pat) begin
            failures++;
            $display("FAIL lat_pulse_end: got dv=%b rdata=%h expected 0 %h", d_valid, d_rdata, pat);
        end
        $display("txn read_latency: d_valid=%b rdata=%h", d_valid, d_rdata);
    endtask

    task automatic test_starvation();
        int wait_cnt;
        logic [AW-1:0] exp_addr;
        do_reset();
        i_req = 1; i_write = 0; i_addr = 15'h0200;
        d_req = 1; d_write = 0; d_addr = 15'h0100;
        for (int g = 0; g < 6; g++) begin
            wait_cnt = 0;
            while (mem_req !== 1'b1 && wait_cnt < 20) begin
                step();
                wait_cnt++;
            end
            checks++;
            if (mem_req !== 1'b1) begin
                failures++;
                $display("FAIL starve_wait: grant %0d got mem_req=%b expected 1 within 20 cycles", g, mem_req);
                break;
            end
            exp_addr = (g == 4) ? 15'h0200 : 15'h0100;
            checks++;
            if (mem_addr !== exp_addr) begin
                failures++;
                $display("FAIL starve_grant: grant %0d got addr=%h expected %h", g, mem_addr, exp_addr);
            end
            mem_valid = 1; mem_rdata = rand_line();
            step();
            mem_valid = 0;
            checks++;
            if ({i_valid, d_valid} !== ((g == 4) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL starve_owner: grant %0d got iv=%b dv=%b", g, i_valid, d_valid);
            end
            $display("txn starve grant %0d: addr=%h iv=%b dv=%b", g, mem_addr, i_valid, d_valid);
            if (g == 4) i_req = 0;
        end
        d_req = 0;
        step(); step();
    endtask

    task automatic test_write_enc();
        logic [DW-1:0] w;
        logic [AW-1:0] a;
        w = rand_line();
        a = 15'($urandom_range(0, 32767));
        do_reset();
        d_req = 1; d_write = 1; d_addr = a; d_wdata = w; d_wenc = 1;
        step();
        checks++;
        if ({mem_req, mem_write, mem_wenc, mem_addr, mem_wdata} !== {3'b111, a, w}) begin
            failures++;
            $display("FAIL wr_d_cmd: got req=%b wr=%b enc=%b addr=%h expected 1 1 1 %h",
                     mem_req, mem_write, mem_wenc, mem_addr, a);
        end
        mem_valid = 1;
        step();
        mem_valid = 0;
        checks++;
        if ({d_valid, i_valid} !== 2'b10) begin
            failures++;
            $display("FAIL wr_d_valid: got dv=%b iv=%b expected 1 0", d_valid, i_valid);
        end
        d_req = 0;
        step();
        i_req = 1; i_write = 1; i_addr = a; i_wdata = w;
        step();
        checks++;
        if ({mem_req, mem_write, mem_wenc, mem_addr, mem_wdata} !== {3'b110, a, w}) begin
            failures++;
            $display("FAIL wr_i_cmd: got req=%b wr=%b enc=%b addr=%h expected 1 1 0 %h",
                     mem_req, mem_write, mem_wenc, mem_addr, a);
        end
        mem_valid = 1;
        step();
        mem_valid = 0;
        checks++;
        if ({i_valid, d_valid} !== 2'b10) begin
            failures++;
            $display("FAIL wr_i_valid: got iv=%b dv=%b expected 1 0", i_valid, d_valid);
        end
        i_req = 0; d_wenc = 0;
        step();
        $display("txn write_enc: addr=%h done", a);
    endtask

    task automatic test_timeout();
        int n;
        logic [DW-1:0] pat;
        do_reset();
        d_req = 1; d_write = 0; d_addr = 15'h0ABC;
        step();
        n = (mem_req === 1'b1) ? 1 : 0;
        while (mem_req === 1'b1 && n < 400) begin
            step();
            if (mem_req === 1'b1) n++;
        end
        checks++;
        if (n !== TIMEOUT) begin
            failures++;
            $display("FAIL tmo_busy_len: got %0d cycles of mem_req expected %0d", n, TIMEOUT);
        end
        checks++;
        if ({d_err, d_valid, i_err, i_valid} !== 4'b1000) begin
            failures++;
            $display("FAIL tmo_err_pulse: got de=%b dv=%b ie=%b iv=%b expected 1 0 0 0",
                     d_err, d_valid, i_err, i_valid);
        end
        d_req = 0;
        step();
        checks++;
        if (d_err !== 1'b0) begin
            failures++;
            $display("FAIL tmo_err_once: got d_err=%b expected 0", d_err);
        end
        pat = rand_line();
        i_req = 1; i_write = 0; i_addr = 15'h0055;
        step();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 15'h0055}) begin
            failures++;
            $display("FAIL tmo_next_req: got req=%b addr=%h expected 1 0055", mem_req, mem_addr);
        end
        mem_valid = 1; mem_rdata = pat;
        step();
        mem_valid = 0;
        checks++;
        if (i_valid !== 1'b1 || i_rdata !== pat) begin
            failures++;
            $display("FAIL tmo_next_resp: got iv=%b rdata=%h expected 1 %h", i_valid, i_rdata, pat);
        end
        i_req = 0;
        step();
        $display("txn timeout: busy=%0d cycles", n);
    endtask

    task automatic test_reset_busy();
        do_reset();
        d_req = 1; d_write = 1; d_addr = 15'h0777; d_wdata = rand_line(); d_wenc = 1;
        step(); step();
        reset = 1;
        step();
        reset = 0; d_req = 0;
        checks++;
        if ({mem_req, mem_write, mem_wenc, mem_addr, mem_wdata, i_valid, i_err, d_valid, d_err,
             d_renc, i_rdata, d_rdata} !== '0) begin
            failures++;
            $display("FAIL rstbusy_outputs: got req=%b wr=%b addr=%h dv=%b de=%b expected all 0",
                     mem_req, mem_write, mem_addr, d_valid, d_err);
        end
        mem_valid = 1; mem_rdata = rand_line(); mem_renc = 1;
        step();
        mem_valid = 0;
        step();
        checks++;
        if ({mem_req, i_valid, i_err, d_valid, d_err} !== 5'b0 || d_rdata !== '0) begin
            failures++;
            $display("FAIL rstbusy_late_valid: got req=%b iv=%b ie=%b dv=%b de=%b expected 0",
                     mem_req, i_valid, i_err, d_valid, d_err);
        end
        $display("txn reset_in_busy: mem_req=%b", mem_req);
    endtask

    task automatic test_busy_stable();
        logic [AW-1:0] a;
        logic [DW-1:0] w;
        a = 15'h2345; w = rand_line();
        do_reset();
        d_req = 1; d_write = 1; d_addr = a; d_wdata = w; d_wenc = 0;
        step();
        for (int k = 0; k < 3; k++) begin
            d_addr = 15'($urandom_range(0, 32767)); d_wdata = rand_line();
            d_write = 0; d_wenc = 1;
            i_req = 1; i_addr = 15'($urandom_range(0, 32767));
            step();
            checks++;
            if ({mem_req, mem_write, mem_wenc, mem_addr, mem_wdata} !== {3'b110, a, w}) begin
                failures++;
                $display("FAIL stable_cmd: cycle %0d got req=%b wr=%b enc=%b addr=%h expected 1 1 0 %h",
                         k, mem_req, mem_write, mem_wenc, mem_addr, a);
            end
        end
        i_req = 0;
        mem_valid = 1;
        step();
        mem_valid = 0; d_req = 0;
        step();
        mem_valid = 1; mem_rdata = rand_line();
        step();
        mem_valid = 0;
        checks++;
        if ({mem_req, i_valid, d_valid, i_err, d_err} !== 5'b0) begin
            failures++;
            $display("FAIL spurious_valid: got req=%b iv=%b dv=%b ie=%b de=%b expected 0",
                     mem_req, i_valid, d_valid, i_err, d_err);
        end
        step();
        $display("txn busy_stable: addr=%h", a);
    endtask

    // Random traffic from both requesters against a line-memory reference.
    task automatic test_random();
        logic [DW-1:0] ref_mem [8];
        logic          ref_enc [8];
        logic [DW-1:0] env_mem [8];
        logic          env_enc [8];
        logic [144:0]  exp_cmd;
        int starve, done, i_age, d_age, delay;
        logic i_pend, d_pend, resp_active, exp_pulse, own_i, prev_i, prev_d, prev_mreq, i_just, d_just;
        starve = 0; done = 0; i_age = 0; d_age = 0; delay = 0;
        i_pend = 0; d_pend = 0; resp_active = 0; exp_pulse = 0; own_i = 0;
        prev_i = 0; prev_d = 0; prev_mreq = 0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            ref_mem[k] = rand_line(); env_mem[k] = ref_mem[k];
            ref_enc[k] = 1'($urandom_range(0, 1)); env_enc[k] = ref_enc[k];
        end
        for (int cyc = 0; cyc < 4000 && done < 150; cyc++) begin
            i_just = 0; d_just = 0;
            checks++;
            if ((i_valid | d_valid | i_err | d_err) !== exp_pulse) begin
                failures++;
                $display("FAIL rnd_pulse_timing: cycle %0d got iv=%b dv=%b ie=%b de=%b expected pulse=%b",
                         cyc, i_valid, d_valid, i_err, d_err, exp_pulse);
            end
            if (exp_pulse) begin
                checks++;
                if ({i_valid, d_valid, i_err, d_err} !== {own_i, ~own_i, 2'b00}) begin
                    failures++;
                    $display("FAIL rnd_pulse_owner: got iv=%b dv=%b expected iv=%b dv=%b",
                             i_valid, d_valid, own_i, ~own_i);
                end
                if (own_i) begin
                    if (!i_write) begin
                        checks++;
                        if (i_rdata !== ref_mem[i_addr[2:0]]) begin
                            failures++;
                            $display("FAIL rnd_i_rdata: addr %0d got %h expected %h",
                                     i_addr, i_rdata, ref_mem[i_addr[2:0]]);
                        end
                    end else begin
                        ref_mem[i_addr[2:0]] = i_wdata;
                        ref_enc[i_addr[2:0]] = 1'b0;
                    end
                    $display("txn rnd %0d: I %s addr=%0d", done, i_write ? "wr" : "rd", i_addr);
                    i_req = 0; i_pend = 0; i_just = 1;
                end else begin
                    if (!d_write) begin
                        checks++;
                        if ({d_renc, d_rdata} !== {ref_enc[d_addr[2:0]], ref_mem[d_addr[2:0]]}) begin
                            failures++;
                            $display("FAIL rnd_d_rdata: addr %0d got enc=%b %h expected enc=%b %h",
                                     d_addr, d_renc, d_rdata, ref_enc[d_addr[2:0]], ref_mem[d_addr[2:0]]);
                        end
                    end else begin
                        ref_mem[d_addr[2:0]] = d_wdata;
                        ref_enc[d_addr[2:0]] = d_wenc;
                    end
                    $display("txn rnd %0d: D %s addr=%0d", done, d_write ? "wr" : "rd", d_addr);
                    d_req = 0; d_pend = 0; d_just = 1;
                end
                done++;
            end
            exp_pulse = 0;

            if (mem_req === 1'b1 && prev_mreq === 1'b0) begin
                checks++;
                if (!(prev_i | prev_d)) begin
                    failures++;
                    $display("FAIL rnd_grant_noreq: cycle %0d mem_req rose with no request", cyc);
                end
                own_i = prev_i & (~prev_d | (starve == STARVE_LIMIT));
                exp_cmd = own_i ? {i_write, i_addr, i_wdata, 1'b0} : {d_write, d_addr, d_wdata, d_wenc};
                checks++;
                if ({mem_write, mem_addr, mem_wdata, mem_wenc} !== exp_cmd) begin
                    failures++;
                    $display("FAIL rnd_grant_cmd: cycle %0d got wr=%b addr=%h enc=%b expected owner %s",
                             cyc, mem_write, mem_addr, mem_wenc, own_i ? "I" : "D");
                end
                if (own_i) starve = 0;
                else if (prev_i) starve = (starve < STARVE_LIMIT) ? starve + 1 : starve;
                else starve = 0;
                resp_active = 1;
                delay = $urandom_range(0, 3);
            end
            prev_mreq = mem_req;

            mem_valid = 0; mem_rdata = rand_line(); mem_renc = 1'($urandom_range(0, 1));
            if (resp_active) begin
                if (delay == 0) begin
                    mem_valid = 1;
                    if (mem_write) begin
                        env_mem[mem_addr[2:0]] = mem_wdata;
                        env_enc[mem_addr[2:0]] = mem_wenc;
                    end else begin
                        mem_rdata = env_mem[mem_addr[2:0]];
                        mem_renc  = env_enc[mem_addr[2:0]];
                    end
                    resp_active = 0;
                    exp_pulse = 1;
                end else begin
                    delay--;
                end
            end

            if (!i_pend && !i_just && $urandom_range(0, 2) == 0) begin
                i_pend = 1; i_req = 1; i_age = 0;
                i_write = 1'($urandom_range(0, 1));
                i_addr = 15'($urandom_range(0, 7)); i_wdata = rand_line();
            end
            if (!d_pend && !d_just && $urandom_range(0, 1) == 0) begin
                d_pend = 1; d_req = 1; d_age = 0;
                d_write = 1'($urandom_range(0, 1)); d_wenc = 1'($urandom_range(0, 1));
                d_addr = 15'($urandom_range(0, 7)); d_wdata = rand_line();
            end
            if (i_pend) i_age++;
            if (d_pend) d_age++;
            if (i_age > 200 || d_age > 200) begin
                checks++;
                failures++;
                $display("FAIL rnd_wait_bound: cycle %0d i_age=%0d d_age=%0d expected <= 200", cyc, i_age, d_age);
                break;
            end
            prev_i = i_req; prev_d = d_req;
            step();
        end
        checks++;
        if (done < 150) begin
            failures++;
            $display("FAIL rnd_completions: got %0d expected 150", done);
        end
        i_req = 0; d_req = 0; mem_valid = 0;
        step(); step();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_read_latency();
        test_starvation();
        test_write_enc();
        test_timeout();
        test_reset_busy();
        test_busy_stable();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
